color_scan_ctrl: RTL and testbench
==================================

Name: color_scan_ctrl

Overview:
Sequencer for the TCS3200-style colour sensor front end. It steps the sensor photodiode filter through red, green and blue. For each filter it counts rising edges of the sensor frequency output over a fixed gate window, then picks the dominant channel. The resulting color_code is what the 7-segment output driver consumes; color_code and the three raw counts are exposed for debug.

Parameters:
GATE_CYCLES, 50000, clk cycles per measurement window (1 ms at 50 MHz); minimum 2
SETTLE_CYCLES, 500, clk cycles waited after a filter change before counting; minimum 1
CNT_W, 16, width of each channel edge counter
MIN_COUNT, 100, minimum winning count for a valid colour; below it the result is unknown

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  begin one R-G-B scan; sampled only in IDLE
sensor_out  in  1  asynchronous square wave from the sensor
s2  out  1  sensor filter select bit S2
s3  out  1  sensor filter select bit S3
busy  out  1  high from the cycle after start is accepted until DECIDE completes
valid  out  1  one-cycle pulse when color_code and the counts update
color_code  out  2  00 red, 01 green, 10 blue, 11 unknown
count_r  out  CNT_W  last red edge count
count_g  out  CNT_W  last green edge count
count_b  out  CNT_W  last blue edge count

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high, and overrides everything, including a scan in progress.
- Reset values: FSM=IDLE, s2=1, s3=0 (clear filter), busy=0, valid=0, color_code=11, count_r/g/b=0, timer=0, synchroniser flops=0.
- Input sync: sensor_out passes through a 2-flop synchroniser plus an edge-detect flop. A rising edge is sync2 & ~sync3.
- Filter encoding (s2,s3): red (0,0), green (1,1), blue (0,1), clear (1,0).
  - The clear filter is driven in IDLE and DECIDE.
  - Filter outputs are registered and change on the state-entry edge.
- FSM: IDLE -> SET_R -> GATE_R -> SET_G -> GATE_G -> SET_B -> GATE_B -> DECIDE -> IDLE.
  - IDLE: if start=1, go to SET_R and load the timer with SETTLE_CYCLES-1.
  - SET_x: count down; at 0 go to GATE_x, load GATE_CYCLES-1 and clear the working counter.
  - GATE_x: each detected edge increments the working counter; the counter saturates at 2^CNT_W-1 with no wrap. At timer 0, the final count (including an edge seen in that last cycle) is latched into a hidden per-channel register, and the FSM moves on.
  - DECIDE (exactly one cycle): on the next edge, count_r/g/b, color_code and valid=1 update together, and the FSM returns to IDLE.
- Timing:
  - SET_x lasts SETTLE_CYCLES cycles; GATE_x lasts GATE_CYCLES cycles.
  - valid asserts 3*(SETTLE_CYCLES+GATE_CYCLES)+1 cycles after the start-sampling edge.
  - busy is high in every state except IDLE.
- Start handling: start is ignored while busy, with no queueing. Holding start high gives back-to-back scans, with exactly one IDLE cycle between them (valid is high in that cycle).
- Decision rule:
  - color_code is the channel whose count is strictly greater than both others, and that count must be >= MIN_COUNT.
  - Any tie for the maximum, or a maximum below MIN_COUNT, gives 11.
  - Comparisons are unsigned CNT_W-bit.
- Outputs hold between valid pulses. The published count_* values change only on valid.
- Edges arriving during SET_x or IDLE are discarded. Synchroniser latency (2 cycles) may shift up to 2 edges across window boundaries; this is accepted.
- Reset mid-scan discards the partial counts and returns to the reset values on the same edge.

Decomposition:
- Shared package color_pkg holds:
  - colour code constants COLOR_RED=2'b00, COLOR_GREEN=2'b01, COLOR_BLUE=2'b10, COLOR_UNKNOWN=2'b11;
  - filter select constants (s2,s3) per channel;
  - the FSM state encoding.
- One natural sub-module, edge_counter: synchroniser, rising-edge detect, saturating counter with clear and enable.
- FSM, timer and decision logic stay in color_scan_ctrl.

Test Plan:
- Bench parameters GATE_CYCLES=100, SETTLE_CYCLES=4, CNT_W=8, MIN_COUNT=5. sensor_out period 4 in red, 10 in green, 20 in blue; start pulse -> valid after 313 cycles, count_r=25±1, count_g=10±1, count_b=5±1, color_code=00.
- Periods 20/4/10 (R/G/B) -> color_code=01; periods 20/10/4 -> color_code=10; s2,s3 observed as (0,0),(1,1),(0,1) during the respective windows, (1,0) otherwise.
- Equal period 8 on all channels -> counts 12–13 each; if all equal, color_code=11. sensor_out held low -> all counts 0, color_code=11.
- CNT_W=4 with period 2 in red -> count_r saturates at 15, no wrap; result still red if green and blue are lower.
- rst asserted during GATE_G -> next cycle busy=0, valid=0, color_code=11, counts 0; a new start runs a full clean scan.
- start pulsed during GATE_R -> ignored, only one valid. start held high -> valid every 314 cycles, busy low exactly 1 cycle between scans.

Source files
------------

// File: rtl/color_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// color_pkg
//   Shared definitions for the colour sensor scan sequencer:
//     - colour codes published on color_code
//     - filter select values {s2,s3} for each photodiode group
//     - channel indices used to address the per-channel registers
//     - FSM state encoding and the state -> filter mapping
// ---------------------------------------------------------------------------
package color_pkg;

    // Colour codes. The channel index doubles as the colour code.
    localparam logic [1:0] COLOR_RED     = 2'b00;
    localparam logic [1:0] COLOR_GREEN   = 2'b01;
    localparam logic [1:0] COLOR_BLUE    = 2'b10;
    localparam logic [1:0] COLOR_UNKNOWN = 2'b11;

    // Filter select values, packed as {s2, s3}.
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_CLEAR = 2'b10;

    // Channel indices into the per-channel register banks.
    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;
    localparam int NUM_CH = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET_R  = 3'd1,
        ST_GATE_R = 3'd2,
        ST_SET_G  = 3'd3,
        ST_GATE_G = 3'd4,
        ST_SET_B  = 3'd5,
        ST_GATE_B = 3'd6,
        ST_DECIDE = 3'd7
    } state_t;

    // Filter that must be applied while the FSM sits in a given state.
    // The settle phase already selects the channel's filter so the sensor
    // output has stabilised by the time counting starts.
    function automatic logic [1:0] state_filter(input state_t st);
        case (st)
            ST_SET_R, ST_GATE_R: return FILT_RED;
            ST_SET_G, ST_GATE_G: return FILT_GREEN;
            ST_SET_B, ST_GATE_B: return FILT_BLUE;
            default:             return FILT_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/color_scan_ctrl_edge_counter.sv
// ---------------------------------------------------------------------------
// edge_counter
//   Brings the asynchronous sensor square wave into the clk domain, detects
//   its rising edges and counts them with a saturating counter.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous reset, active-high
//   sig_i  in   asynchronous input (sensor frequency output)
//   clr_i  in   synchronous clear of the count (wins over counting)
//   en_i   in   count enable; edges seen while low are dropped
//   cnt_o  out  count including an edge detected in the current cycle,
//               i.e. the value the counter will hold after this edge
// ---------------------------------------------------------------------------
module edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             sync3_q;
    logic             rise;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // sync1/sync2 form the metastability synchroniser, sync3 is the
    // previous synchronised sample used for edge detection.
    assign rise = sync2_q & ~sync3_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && rise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The look-ahead value lets the controller capture an edge that lands
    // in the very last cycle of a window without waiting another cycle.
    assign cnt_o = cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            cnt_q   <= clr_i ? '0 : cnt_d;
        end
    end

endmodule

// File: rtl/color_scan_ctrl.sv
// ---------------------------------------------------------------------------
// color_scan_ctrl
//   Steps a TCS3200-style colour sensor through its red, green and blue
//   filters. For each filter it waits SETTLE_CYCLES, then counts sensor
//   rising edges for GATE_CYCLES, and finally picks the dominant channel.
//
// Parameters:
//   GATE_CYCLES    clk cycles per counting window (>= 2)
//   SETTLE_CYCLES  clk cycles after a filter change before counting (>= 1)
//   CNT_W          width of each channel edge count
//   MIN_COUNT      smallest winning count accepted as a real colour
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   start        in   begin one R-G-B scan (only looked at in IDLE)
//   sensor_out   in   asynchronous square wave from the sensor
//   s2, s3       out  registered filter select
//   busy         out  high in every state except IDLE
//   valid        out  one-cycle pulse when color_code and counts update
//   color_code   out  00 red, 01 green, 10 blue, 11 unknown
//   count_r/g/b  out  edge counts of the last completed scan
// ---------------------------------------------------------------------------
module color_scan_ctrl
    import color_pkg::*;
#(
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 500,
    parameter int CNT_W         = 16,
    parameter int MIN_COUNT     = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sensor_out,
    output logic             s2,
    output logic             s3,
    output logic             busy,
    output logic             valid,
    output logic [1:0]       color_code,
    output logic [CNT_W-1:0] count_r,
    output logic [CNT_W-1:0] count_g,
    output logic [CNT_W-1:0] count_b
);

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    // One extra bit so a MIN_COUNT above the counter range can never be met
    // instead of wrapping into a small threshold.
    localparam logic [CNT_W:0] MIN_CMP = (CNT_W + 1)'(MIN_COUNT);

    state_t                       state_q;
    state_t                       state_d;
    logic [TMR_W-1:0]             timer_q;
    logic [TMR_W-1:0]             timer_d;
    logic                         timer_zero;

    logic                         cnt_clr;
    logic                         cnt_en;
    logic [CNT_W-1:0]             work_cnt;
    logic [NUM_CH-1:0]            latch_en;
    logic                         publish;

    logic [NUM_CH-1:0][CNT_W-1:0] hold_w;
    logic [NUM_CH-1:0][CNT_W-1:0] pub_w;

    logic [1:0]                   filt_q;
    logic                         valid_q;
    logic [1:0]                   color_q;
    logic [1:0]                   color_d;

    // -----------------------------------------------------------------------
    // Edge counting front end. A single working counter is reused for all
    // three channels; it is cleared on entry to every gate window.
    // -----------------------------------------------------------------------
    edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk   (clk),
        .rst   (rst),
        .sig_i (sensor_out),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (work_cnt)
    );

    assign timer_zero = (timer_q == '0);

    // -----------------------------------------------------------------------
    // Sequencer next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        latch_en = '0;
        publish  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SET_R;
                    timer_d = SETTLE_LOAD;
                end
            end

            ST_SET_R, ST_SET_G, ST_SET_B: begin
                if (timer_zero) begin
                    cnt_clr = 1'b1;
                    timer_d = GATE_LOAD;
                    case (state_q)
                        ST_SET_R: state_d = ST_GATE_R;
                        ST_SET_G: state_d = ST_GATE_G;
                        default:  state_d = ST_GATE_B;
                    endcase
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_GATE_R, ST_GATE_G, ST_GATE_B: begin
                cnt_en = 1'b1;
                if (timer_zero) begin
                    case (state_q)
                        ST_GATE_R: begin
                            latch_en[CH_R] = 1'b1;
                            state_d        = ST_SET_G;
                            timer_d        = SETTLE_LOAD;
                        end
                        ST_GATE_G: begin
                            latch_en[CH_G] = 1'b1;
                            state_d        = ST_SET_B;
                            timer_d        = SETTLE_LOAD;
                        end
                        default: begin
                            latch_en[CH_B] = 1'b1;
                            state_d        = ST_DECIDE;
                            timer_d        = '0;
                        end
                    endcase
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            ST_DECIDE: begin
                publish = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Dominant-channel decision on the latched counts. A channel wins only
    // when it is strictly above both others, so any tie for the maximum
    // falls through to unknown.
    // -----------------------------------------------------------------------
    always_comb begin
        color_d = COLOR_UNKNOWN;
        if ((hold_w[CH_R] > hold_w[CH_G]) && (hold_w[CH_R] > hold_w[CH_B]) &&
            ({1'b0, hold_w[CH_R]} >= MIN_CMP)) begin
            color_d = COLOR_RED;
        end else if ((hold_w[CH_G] > hold_w[CH_R]) && (hold_w[CH_G] > hold_w[CH_B]) &&
                     ({1'b0, hold_w[CH_G]} >= MIN_CMP)) begin
            color_d = COLOR_GREEN;
        end else if ((hold_w[CH_B] > hold_w[CH_R]) && (hold_w[CH_B] > hold_w[CH_G]) &&
                     ({1'b0, hold_w[CH_B]} >= MIN_CMP)) begin
            color_d = COLOR_BLUE;
        end
    end

    // -----------------------------------------------------------------------
    // Control and output registers. The filter select is computed from the
    // next state so it changes on the same edge the state is entered.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            filt_q  <= FILT_CLEAR;
            valid_q <= 1'b0;
            color_q <= COLOR_UNKNOWN;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            filt_q  <= state_filter(state_d);
            valid_q <= publish;
            if (publish) begin
                color_q <= color_d;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel registers: a hidden capture at the end of each window and
    // the published copy that only moves when valid is raised, so a scan in
    // progress never disturbs the visible counts.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            logic [CNT_W-1:0] hold_q;
            logic [CNT_W-1:0] pub_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    hold_q <= '0;
                    pub_q  <= '0;
                end else begin
                    if (latch_en[gi]) begin
                        hold_q <= work_cnt;
                    end
                    if (publish) begin
                        pub_q <= hold_q;
                    end
                end
            end

            assign hold_w[gi] = hold_q;
            assign pub_w[gi]  = pub_q;
        end
    endgenerate

    assign s2         = filt_q[1];
    assign s3         = filt_q[0];
    assign busy       = (state_q != ST_IDLE);
    assign valid      = valid_q;
    assign color_code = color_q;
    assign count_r    = pub_w[CH_R];
    assign count_g    = pub_w[CH_G];
    assign count_b    = pub_w[CH_B];

endmodule

// File: tb/tb_color_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_color_scan_ctrl
//   Two sequencers share clock, reset, start and sensor stimulus: one with
//   8-bit counts, one with 4-bit counts to exercise saturation. The bench
//   synthesises the sensor waveform for each filter window, counts the
//   rising edges it produced, and predicts counts and colour code.
//   Sensor activity is kept a few cycles clear of window boundaries so the
//   expected counts are exact despite synchroniser latency.
// ---------------------------------------------------------------------------
module tb_color_scan_ctrl;

    localparam int G      = 100;
    localparam int S      = 4;
    localparam int MINC   = 5;
    localparam int MARGIN = 3;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sensor;

    logic       a_s2, a_s3, a_busy, a_valid;
    logic [1:0] a_color;
    logic [7:0] a_cr, a_cg, a_cb;

    logic       b_s2, b_s3, b_busy, b_valid;
    logic [1:0] b_color;
    logic [3:0] b_cr, b_cg, b_cb;

    int checks;
    int errors;

    // Bench copy of what the published outputs should currently show.
    logic [23:0] last_a;
    logic [11:0] last_b;
    logic [1:0]  last_ca;
    logic [1:0]  last_cb;

    color_scan_ctrl #(
        .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(8), .MIN_COUNT(MINC)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .sensor_out(sensor),
        .s2(a_s2), .s3(a_s3), .busy(a_busy), .valid(a_valid),
        .color_code(a_color), .count_r(a_cr), .count_g(a_cg), .count_b(a_cb)
    );

    color_scan_ctrl #(
        .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4), .MIN_COUNT(MINC)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .sensor_out(sensor),
        .s2(b_s2), .s3(b_s3), .busy(b_busy), .valid(b_valid),
        .color_code(b_color), .count_r(b_cr), .count_g(b_cg), .count_b(b_cb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference decision: unique maximum at or above the threshold wins.
    function automatic logic [1:0] ref_decide(input int c0, input int c1, input int c2);
        int c[3];
        int best;
        int nbest;
        int idx;
        c     = '{c0, c1, c2};
        best  = -1;
        nbest = 0;
        idx   = 0;
        for (int k = 0; k < 3; k++) begin
            if (c[k] > best) begin
                best  = c[k];
                idx   = k;
                nbest = 1;
            end else if (c[k] == best) begin
                nbest++;
            end
        end
        if (nbest == 1 && best >= MINC) return 2'(idx);
        return 2'b11;
    endfunction

    function automatic logic [1:0] ref_filter(input int ch);
        case (ch)
            0:       return 2'b00;
            1:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        sensor = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_s2, a_s3, a_busy, a_valid, a_color} !== 6'b10_0_0_11 ||
            {a_cr, a_cg, a_cb} !== 24'h0) begin
            errors++;
            $display("FAIL reset_a: got s2s3=%b busy=%b valid=%b color=%b counts=%h, expected 10 0 0 11 000000",
                     {a_s2, a_s3}, a_busy, a_valid, a_color, {a_cr, a_cg, a_cb});
        end
        checks++;
        if ({b_s2, b_s3, b_busy, b_valid, b_color} !== 6'b10_0_0_11 ||
            {b_cr, b_cg, b_cb} !== 12'h0) begin
            errors++;
            $display("FAIL reset_b: got s2s3=%b busy=%b valid=%b color=%b counts=%h, expected 10 0 0 11 000",
                     {b_s2, b_s3}, b_busy, b_valid, b_color, {b_cr, b_cg, b_cb});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_busy !== 1'b0 || a_valid !== 1'b0 || {a_s2, a_s3} !== 2'b10) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b valid=%b s2s3=%b, expected 0 0 10",
                     a_busy, a_valid, {a_s2, a_s3});
        end
        last_a  = '0;
        last_b  = '0;
        last_ca = 2'b11;
        last_cb = 2'b11;
        $display("reset: done");
    endtask

    // One R-G-B scan. Entered #1 after a clock edge with the DUT able to
    // accept start on the next edge. per_x = 0 holds the sensor low.
    // poke >= 0 pulses start at that cycle index of the red phase.
    task automatic run_scan(input string name, input int per_r, input int per_g,
                            input int per_b, input bit hold_start, input int poke);
        int          per[3];
        int          rises[3];
        int          j;
        logic        v;
        logic        prev;
        bit          filt_ok, busy_ok, hold_ok;
        logic [1:0]  bad_f, bad_e;
        logic [23:0] exp_a;
        logic [11:0] exp_b;
        logic [1:0]  exp_ca, exp_cb;

        per     = '{per_r, per_g, per_b};
        filt_ok = 1'b1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        bad_f   = 2'b00;
        bad_e   = 2'b00;

        start = 1'b1;
        @(posedge clk);
        #1;
        for (int ch = 0; ch < 3; ch++) begin
            rises[ch] = 0;
            prev      = 1'b0;
            for (int i = 0; i < S + G; i++) begin
                if (!hold_start) start = (ch == 0 && i == poke);
                j = i - S;
                v = 1'b0;
                if (per[ch] > 0 && j >= MARGIN && j <= G - 1 - MARGIN)
                    v = ((j - MARGIN) % per[ch]) >= (per[ch] / 2);
                if (v && !prev) rises[ch]++;
                prev   = v;
                sensor = v;
                if ({a_s2, a_s3} !== ref_filter(ch) || {b_s2, b_s3} !== ref_filter(ch)) begin
                    if (filt_ok) begin
                        bad_f = {a_s2, a_s3};
                        bad_e = ref_filter(ch);
                    end
                    filt_ok = 1'b0;
                end
                if (a_busy !== 1'b1 || a_valid !== 1'b0 || b_busy !== 1'b1 || b_valid !== 1'b0)
                    busy_ok = 1'b0;
                if ({a_cr, a_cg, a_cb} !== last_a || {b_cr, b_cg, b_cb} !== last_b ||
                    a_color !== last_ca || b_color !== last_cb)
                    hold_ok = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        sensor = 1'b0;
        if (!hold_start) start = 1'b0;

        exp_a  = {8'(rises[0]), 8'(rises[1]), 8'(rises[2])};
        exp_b  = {4'(sat15(rises[0])), 4'(sat15(rises[1])), 4'(sat15(rises[2]))};
        exp_ca = ref_decide(rises[0], rises[1], rises[2]);
        exp_cb = ref_decide(sat15(rises[0]), sat15(rises[1]), sat15(rises[2]));

        checks++;
        if (!filt_ok) begin
            errors++;
            $display("FAIL %s filter: s2s3=%b during window, expected %b", name, bad_f, bad_e);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL %s busy_window: busy/valid not 1/0 throughout scan, expected busy=1 valid=0", name);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL %s output_hold: published outputs changed mid-scan, expected %h/%b", name, last_a, last_ca);
        end

        // DECIDE cycle.
        checks++;
        if ({a_busy, a_valid, a_s2, a_s3} !== 4'b1010) begin
            errors++;
            $display("FAIL %s decide_cycle: busy,valid,s2,s3=%b expected 1010", name,
                     {a_busy, a_valid, a_s2, a_s3});
        end
        @(posedge clk);
        #1;

        // Publish cycle: valid pulse, FSM back in IDLE.
        checks++;
        if ({a_valid, a_busy, b_valid, b_busy, a_s2, a_s3} !== 6'b10_10_10) begin
            errors++;
            $display("FAIL %s valid_cycle: valid,busy(a,b),s2s3=%b expected 101010", name,
                     {a_valid, a_busy, b_valid, b_busy, a_s2, a_s3});
        end
        checks++;
        if ({a_cr, a_cg, a_cb} !== exp_a) begin
            errors++;
            $display("FAIL %s counts_a: got %h expected %h", name, {a_cr, a_cg, a_cb}, exp_a);
        end
        checks++;
        if (a_color !== exp_ca) begin
            errors++;
            $display("FAIL %s color_a: got %b expected %b", name, a_color, exp_ca);
        end
        checks++;
        if ({b_cr, b_cg, b_cb} !== exp_b) begin
            errors++;
            $display("FAIL %s counts_b: got %h expected %h", name, {b_cr, b_cg, b_cb}, exp_b);
        end
        checks++;
        if (b_color !== exp_cb) begin
            errors++;
            $display("FAIL %s color_b: got %b expected %b", name, b_color, exp_cb);
        end
        last_a  = exp_a;
        last_b  = exp_b;
        last_ca = exp_ca;
        last_cb = exp_cb;

        $display("scan %s: per=%0d/%0d/%0d edges=%0d/%0d/%0d color8=%b color4=%b",
                 name, per_r, per_g, per_b, rises[0], rises[1], rises[2], exp_ca, exp_cb);

        if (!hold_start) begin
            busy_ok = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk);
                #1;
                if (a_valid !== 1'b0 || a_busy !== 1'b0 || {a_cr, a_cg, a_cb} !== last_a)
                    busy_ok = 1'b0;
            end
            checks++;
            if (!busy_ok) begin
                errors++;
                $display("FAIL %s after_scan: extra activity after valid, expected idle with counts %h", name, last_a);
            end
        end
    endtask

    task automatic test_directed();
        run_scan("red",      4, 10, 20, 1'b0, -1);
        run_scan("green",   20,  4, 10, 1'b0, -1);
        run_scan("blue",    20, 10,  4, 1'b0, -1);
        run_scan("equal",    8,  8,  8, 1'b0, -1);
        run_scan("dark",     0,  0,  0, 1'b0, -1);
        run_scan("low_min",  0, 24,  0, 1'b0, -1);
    endtask

    task automatic test_saturation();
        run_scan("sat_red",  2, 20, 20, 1'b0, -1);
        run_scan("sat_tie",  2,  4, 24, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        // Put something non-trivial in the published registers first.
        run_scan("pre_rst", 6, 12, 18, 1'b0, -1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (S + G + S + 30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({a_busy, a_valid, a_color, a_s2, a_s3} !== 6'b0_0_11_10 || {a_cr, a_cg, a_cb} !== 24'h0) begin
            errors++;
            $display("FAIL reset_mid_a: busy=%b valid=%b color=%b s2s3=%b counts=%h, expected 0 0 11 10 000000",
                     a_busy, a_valid, a_color, {a_s2, a_s3}, {a_cr, a_cg, a_cb});
        end
        checks++;
        if ({b_busy, b_valid, b_color} !== 4'b0_0_11 || {b_cr, b_cg, b_cb} !== 12'h0) begin
            errors++;
            $display("FAIL reset_mid_b: busy=%b valid=%b color=%b counts=%h, expected 0 0 11 000",
                     b_busy, b_valid, b_color, {b_cr, b_cg, b_cb});
        end
        $display("reset_mid: applied during green window");
        last_a  = '0;
        last_b  = '0;
        last_ca = 2'b11;
        last_cb = 2'b11;
        // Sensor chatter while idle must not leak into the next scan.
        for (int k = 0; k < 8; k++) begin
            sensor = k[0];
            @(posedge clk);
            #1;
        end
        sensor = 1'b0;
        run_scan("post_rst", 10, 4, 20, 1'b0, -1);
    endtask

    task automatic test_random();
        int pr, pg, pb;
        for (int n = 0; n < 6; n++) begin
            pr = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 24));
            pg = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 24));
            pb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 24));
            run_scan($sformatf("rand%0d", n), pr, pg, pb, 1'b0, -1);
        end
    endtask

    task automatic test_start_ignored();
        run_scan("poke", 12, 5, 9, 1'b0, S + 10);
    endtask

    task automatic test_back_to_back();
        run_scan("b2b_0", 4, 10, 20, 1'b1, -1);
        run_scan("b2b_1", 20, 4, 10, 1'b1, -1);
        run_scan("b2b_2", 20, 10, 4, 1'b0, -1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_saturation();
        test_reset_mid();
        test_random();
        test_start_ignored();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
